// File: rtl/sdf_butterfly_stage_pkg.sv
// Shared FFT constants and elaboration-time helpers for the R2SDF pipeline.
package sdf_butterfly_stage_pkg;

  localparam int N_FFT    = 2048;
  localparam int TW_IDX_W = 10;

  // Ceiling log2. Returns 0 for 1, which callers guard where a zero-width
  // vector would otherwise appear.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdf_butterfly_stage_delay_line.sv
// Circular feedback buffer of DELAY entries. It advances one slot per enabled
// cycle, and dout always shows the entry written DELAY enabled cycles earlier.
module sdf_delay_line
  import sdf_butterfly_stage_pkg::*;
#(
  parameter int DELAY = 1024,
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DELAY > 1) ? clog2(DELAY) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  assign ptr_next = (ptr_reg == PTR_W'(DELAY - 1)) ? '0 : ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (en) begin
      ptr_reg <= ptr_next;
    end
  end

  generate
    if (DELAY >= 16) begin : g_ram
      // Registered read fetches the slot needed on the next enabled cycle,
      // so the butterfly sees the old contents of the current slot with no
      // extra latency while the array still maps onto block RAM.
      logic [WIDTH-1:0] mem [DELAY];
      logic [WIDTH-1:0] rd_reg;

      always_ff @(posedge clk) begin
        if (en) begin
          mem[ptr_reg] <= din;
          rd_reg       <= mem[ptr_next];
        end
      end

      assign dout = rd_reg;
    end else begin : g_flops
      logic [WIDTH-1:0] mem [DELAY];

      always_ff @(posedge clk) begin
        if (en) begin
          mem[ptr_reg] <= din;
        end
      end

      assign dout = mem[ptr_reg];
    end
  endgenerate

endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 SDF decimation-in-frequency butterfly stage. It emits the widened
// sum or difference together with the twiddle index for the following multiplier.
module sdf_butterfly_stage
  import sdf_butterfly_stage_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DELAY = 1024,
  parameter int N_FFT = sdf_butterfly_stage_pkg::N_FFT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [WIDTH-1:0]    in_r,
  input  logic signed [WIDTH-1:0]    in_i,
  output logic                       out_valid,
  output logic signed [WIDTH:0]      out_r,
  output logic signed [WIDTH:0]      out_i,
  output logic [TW_IDX_W-1:0]        tw_idx,
  output logic                       tw_mul
);

  localparam int W1       = WIDTH + 1;
  localparam int CNT_W    = clog2(2 * DELAY);
  localparam int TW_SHIFT = clog2(N_FFT / (2 * DELAY));

  logic [CNT_W-1:0]          cnt_reg;
  logic                      primed_reg;
  logic                      phase_b;
  logic [TW_IDX_W-1:0]       cnt_low;
  logic [TW_IDX_W-1:0]       tw_idx_next;
  logic signed [WIDTH-1:0]   comp_in  [2];
  logic signed [W1-1:0]      comp_res [2];

  // The frame length is a power of two, so the counter MSB marks the
  // second half of the frame.
  assign phase_b = cnt_reg[CNT_W-1];

  assign comp_in[0] = in_r;
  assign comp_in[1] = in_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [W1-1:0] x_ext;
      logic signed [W1-1:0] fifo;
      logic signed [W1-1:0] sum;
      logic signed [W1-1:0] diff;
      logic [W1-1:0]        line_din;
      logic [W1-1:0]        line_dout;

      assign x_ext    = {comp_in[gi][WIDTH-1], comp_in[gi]};
      assign fifo     = line_dout;
      assign sum      = fifo + x_ext;
      assign diff     = fifo - x_ext;
      assign line_din = phase_b ? diff : x_ext;
      assign comp_res[gi] = phase_b ? sum : fifo;

      sdf_delay_line #(
        .DELAY (DELAY),
        .WIDTH (W1)
      ) u_line (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .din   (line_din),
        .dout  (line_dout)
      );
    end
  endgenerate

  assign cnt_low     = TW_IDX_W'(cnt_reg) & TW_IDX_W'(DELAY - 1);
  assign tw_idx_next = phase_b ? '0 : (cnt_low << TW_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      primed_reg <= 1'b0;
      out_valid  <= 1'b0;
      out_r      <= '0;
      out_i      <= '0;
      tw_idx     <= '0;
      tw_mul     <= 1'b0;
    end else begin
      // Nothing meaningful leaves the stage until the first phase A has
      // filled the delay line.
      out_valid <= in_valid && primed_reg;
      if (in_valid) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(DELAY - 1)) begin
          primed_reg <= 1'b1;
        end
        out_r  <= comp_res[0];
        out_i  <= comp_res[1];
        tw_idx <= tw_idx_next;
        tw_mul <= ~phase_b;
      end
    end
  end

endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Directed and randomized checks of two stage instances (DELAY=4, DELAY=1024)
// against a frame-level R2SDF reference model.
module tb_sdf_butterfly_stage;

  localparam int W  = 25;
  localparam int NF = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n [2];
  logic                 iv    [2];
  logic signed [W-1:0]  ir    [2];
  logic signed [W-1:0]  ii    [2];
  logic                 ov    [2];
  logic signed [W:0]    orr   [2];
  logic signed [W:0]    oi    [2];
  logic [9:0]           tidx  [2];
  logic                 tmul  [2];

  sdf_butterfly_stage #(.WIDTH(W), .DELAY(4), .N_FFT(NF)) u_small (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(iv[0]), .in_r(ir[0]), .in_i(ii[0]),
    .out_valid(ov[0]), .out_r(orr[0]), .out_i(oi[0]), .tw_idx(tidx[0]), .tw_mul(tmul[0])
  );

  sdf_butterfly_stage #(.WIDTH(W), .DELAY(1024), .N_FFT(NF)) u_full (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(iv[1]), .in_r(ir[1]), .in_i(ii[1]),
    .out_valid(ov[1]), .out_r(orr[1]), .out_i(oi[1]), .tw_idx(tidx[1]), .tw_mul(tmul[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frame position, first-half samples and the
  // differences owed to the next frame's first half.
  int dd [2] = '{4, 1024};
  int pos [2];
  bit have_prev [2];
  bit known [2];
  int xr [2][1024];
  int xi [2][1024];
  int dr [2][1024];
  int di [2][1024];
  int e_r [2];
  int e_i [2];
  int e_idx [2];
  int e_mul [2];

  task automatic chk(input int s, input string tag,
                     input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL d%0d %s observed=%0d expected=%0d", dd[s], tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int s);
    pos[s] = 0;
    have_prev[s] = 1'b0;
    known[s] = 1'b1;
    e_r[s] = 0; e_i[s] = 0; e_idx[s] = 0; e_mul[s] = 0;
  endtask

  task automatic do_reset(input int s);
    iv[s] = 1'b0;
    rst_n[s] = 1'b0;
    @(posedge clk); #1;
    chk(s, "reset_valid", ov[s], 0);
    chk(s, "reset_r", orr[s], 0);
    chk(s, "reset_i", oi[s], 0);
    chk(s, "reset_idx", tidx[s], 0);
    chk(s, "reset_mul", tmul[s], 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n[s] = 1'b1;
    model_reset(s);
    $display("d%0d reset", dd[s]);
  endtask

  task automatic step(input int s, input bit v, input int r, input int i);
    int k;
    int d;
    bit ev;
    ev = 1'b0;
    d  = dd[s];
    iv[s] = v;
    ir[s] = W'(r);
    ii[s] = W'(i);
    if (v) begin
      k = pos[s];
      if (k < d) begin
        if (have_prev[s]) begin
          ev = 1'b1;
          e_r[s] = dr[s][k]; e_i[s] = di[s][k];
          e_idx[s] = k * (NF / (2 * d)); e_mul[s] = 1;
          known[s] = 1'b1;
        end else begin
          known[s] = 1'b0;
        end
        xr[s][k] = r; xi[s][k] = i;
      end else begin
        ev = 1'b1;
        e_r[s] = xr[s][k-d] + r; e_i[s] = xi[s][k-d] + i;
        dr[s][k-d] = xr[s][k-d] - r; di[s][k-d] = xi[s][k-d] - i;
        e_idx[s] = 0; e_mul[s] = 0;
        known[s] = 1'b1;
      end
      if (k + 1 == 2 * d) begin
        pos[s] = 0;
        have_prev[s] = 1'b1;
      end else begin
        pos[s] = k + 1;
      end
    end
    @(posedge clk); #1;
    iv[s] = 1'b0;
    chk(s, "out_valid", ov[s], ev);
    if (known[s]) begin
      chk(s, "out_r", orr[s], e_r[s]);
      chk(s, "out_i", oi[s], e_i[s]);
      chk(s, "tw_idx", tidx[s], e_idx[s]);
      chk(s, "tw_mul", tmul[s], e_mul[s]);
    end
    if (dd[s] == 4 || ev == 1'b0 || pos[s] % 256 == 0)
      $display("d%0d in v=%0d r=%0d i=%0d -> ov=%0d r=%0d i=%0d idx=%0d mul=%0d",
               dd[s], v, r, i, ov[s], orr[s], oi[s], tidx[s], tmul[s]);
  endtask

  function automatic int rnd25();
    logic signed [W-1:0] t;
    t = W'($urandom);
    return int'(t);
  endfunction

  task automatic align(input int s);
    while (pos[s] != 0) step(s, 1'b1, 0, 0);
  endtask

  task automatic flush(input int s);
    for (int n = 0; n < dd[s]; n++) step(s, 1'b1, 0, 0);
    align(s);
  endtask

  int t1 [8] = '{1, 2, 3, 4, 10, 20, 30, 40};
  int gr [8];
  int gi_v [8];

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; iv[s] = 1'b0; ir[s] = '0; ii[s] = '0;
    end
    do_reset(0);
    do_reset(1);

    // Single butterfly with a known answer.
    for (int n = 0; n < 8; n++) step(0, 1'b1, t1[n], -t1[n]);
    flush(0);

    // Extremes of the input range through both sum and difference.
    gr   = '{-(1 << 24), (1 << 24) - 1, 5, -7, -(1 << 24), -(1 << 24), 3, 0};
    gi_v = '{(1 << 24) - 1, -(1 << 24), 0, 1, -(1 << 24), (1 << 24) - 1, -3, 0};
    for (int n = 0; n < 8; n++) step(0, 1'b1, gr[n], gi_v[n]);
    flush(0);

    // Random frames with random bubbles.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) step(0, 1'b0, 0, 0);
      step(0, 1'b1, rnd25(), rnd25());
    end
    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(0, 1) == 0) step(0, 1'b0, 0, 0);
      step(0, 1'b1, 0, 0);
    end
    align(0);

    // Reset mid-frame at count 5: priming must repeat.
    for (int n = 0; n < 8; n++) step(0, 1'b1, rnd25(), rnd25());
    for (int n = 0; n < 5; n++) step(0, 1'b1, rnd25(), rnd25());
    do_reset(0);
    for (int n = 0; n < 8; n++) step(0, 1'b1, rnd25(), rnd25());
    flush(0);

    // Full-size stage: two back-to-back random frames plus flush.
    for (int n = 0; n < 4096; n++) step(1, 1'b1, rnd25(), rnd25());
    flush(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdf_butterfly_stage.md
# sdf_butterfly_stage

Radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency butterfly stage for the 2048-point FFT pipeline. It sits directly upstream of the complex multiplier stage. Per sample it produces one widened complex value and the matching twiddle index. The multiplier consumes the value as its `A_r`/`A_i` operand. The twiddle ROM consumes the index and supplies `B_r`/`B_i`.

## Interface
- `WIDTH`, 25: input sample width per component, signed.
- `DELAY`, 1024: feedback delay depth. Must be a power of two, 1..1024. A 2048-point frame uses stages 1024, 512, …, 1.
- `N_FFT`, 2048: transform length. Used only for twiddle index scaling.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `in_valid` in 1: a sample is present this cycle.
- `in_r`, `in_i` in WIDTH: input sample, signed.
- `out_valid` out 1: output sample is valid.
- `out_r`, `out_i` out WIDTH+1: output sample, signed. This width equals the downstream multiplier's A width (26 at default).
- `tw_idx` out 10: twiddle index into the N_FFT/2-entry table, aligned with `out_*`.
- `tw_mul` out 1: 1 = difference branch, real twiddle. 0 = sum branch, `tw_idx` = 0, i.e. W^0.

## Operation
- **Flow control.**
  - The stage advances only on cycles with `in_valid`=1. There is no backpressure.
  - The counter `cnt` (log2(2·DELAY) bits) counts valid inputs modulo 2·DELAY.
- **Phase A** (`cnt` < DELAY):
  - Delay-line input = sign-extended `in`.
  - Output = delay-line output, which is the difference from the previous frame's phase B.
  - `tw_mul`=1.
  - `tw_idx` = (`cnt` mod DELAY) · (N_FFT / (2·DELAY)).
- **Phase B** (`cnt` ≥ DELAY):
  - Output = fifo + in (sum).
  - Delay-line input = fifo − in (difference).
  - `tw_mul`=0, `tw_idx`=0.
- **Arithmetic.**
  - Both operands are sign-extended to WIDTH+1 before the add/subtract.
  - Results are WIDTH+1 wide. No rounding, no saturation. Growth is covered by the extra bit.
  - The delay line stores WIDTH+1 bits. Phase-A inputs are sign-extended into it.
- **Delay line.**
  - Circular buffer of DELAY entries.
  - One read and one write of the same address per valid cycle.
  - The pointer advances and wraps at DELAY-1 → 0.
- **Priming.**
  - After reset, the delay line holds undefined data.
  - `out_valid` stays 0 for the first DELAY valid inputs, i.e. the first phase A.
  - After that, `out_valid` follows `in_valid` with a one-cycle delay.
- **Draining.** The last frame's differences leave only as the next frame's phase A is fed. To flush, feed DELAY valid zero samples.

## Timing
- Latency: the input accepted at cycle t produces its output at cycle t+1. All outputs are registered.
- When `in_valid`=0:
  - `out_valid` goes to 0 the next cycle.
  - `out_*`, `tw_idx` and `tw_mul` hold their previous values.
- Reset values, one cycle after `rst_n`=0 is sampled: `out_valid`=0, `out_r`=`out_i`=0, `tw_idx`=0, `tw_mul`=0, `cnt`=0, pointer=0, primed flag=0. Delay-line contents are not reset.
- Reset mid-frame: the partial frame is discarded and the next valid input is `cnt`=0. Priming repeats.
- `cnt` wraps 2·DELAY-1 → 0 with no bubble. Back-to-back frames run at one sample per cycle.
- Every cycle performs a delay-line read and a write to the same address.
  - RAM implementation: read-before-write (old data returned).
  - DELAY=1: a single register.

## Structure
- Shared FFT package:
  - `N_FFT`
  - `TW_IDX_W` = 10
  - a `log2`/`clog2` helper function
- Sub-module `sdf_delay_line`:
  - Parameters: DELAY, width.
  - Ports: `clk`, `rst_n`, `en`, `din`, `dout`.
  - Circular buffer with an internal pointer, reset to 0.
  - Inferable as single-port read-before-write RAM for DELAY ≥ 16, flops otherwise.
- Top level: phase counter, priming flag, butterfly add/sub, twiddle index multiply (shift, since the scaling is a power of two), output registers.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles mid-stream → all outputs 0 next cycle; `out_valid`=0 for the next DELAY valid inputs.
- **Single butterfly** (DELAY=4):
  - Feed x=1,2,3,4,10,20,30,40, then zeros.
  - Phase B outputs: 11,22,33,44, `tw_mul`=0, `tw_idx`=0.
  - Next phase A outputs: −9,−18,−27,−36, `tw_mul`=1, `tw_idx`=0,256,512,768.
- **Width growth** (WIDTH=25): the pair in=−2^24, fifo=−2^24 yields sum −2^25 with no wrap; 2^24−1 − (−2^24) yields 2^25−1.
- **Gapped input:** insert random `in_valid`=0 bubbles into the DELAY=4 sequence → identical output values and order. `out_valid` is low exactly one cycle after each bubble.
- **Full-size stage** (DELAY=1024): two back-to-back random frames plus a zero flush, compared against a bit-exact R2SDF model. `tw_idx` step = 1, range 0..1023.
- **Reset mid-frame** at `cnt`=5 (DELAY=4): the next frame starts at `cnt`=0 and priming repeats. No stale difference appears with `out_valid`=1.
